tmec_serial_sched: RTL and testbench

//  Cycle scheduler for the serial inversionless t-error BCH key-equation datapath.

---
 rtl/tmec_serial_sched.sv | 215 +++++++++++++++++++++
 tb/tb_tmec_serial_sched.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmec_serial_sched.sv
// Cycle scheduler for the serial inversionless BCH key-equation datapath: LOAD, T iterations of M cycles, DONE.
// Optional macro TMEC_SCHED_FAIL_EN adds the loc_fail (L > T) output.
module tmec_serial_sched #(
    parameter int M = 4,
    parameter int T = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      drnzero,
    input  logic                      out_ready,
    output logic                      synpe,
    output logic                      snce,
    output logic                      msmpe,
    output logic                      cbBeg,
    output logic                      caLast,
    output logic                      cce,
    output logic                      dringPe,
    output logic                      c0first,
    output logic                      bsel,
    output logic                      busy,
    output logic                      loc_valid,
`ifdef TMEC_SCHED_FAIL_EN
    output logic                      loc_fail,
`endif
    output logic [$clog2(2*T)-1:0]    loc_deg
);

    localparam int BW = $clog2(M);
    localparam int RW = $clog2(T);
    localparam int LW = $clog2(2*T);
    localparam logic [BW-1:0] B_LAST = BW'(M - 1);
    localparam logic [RW-1:0] R_LAST = RW'(T - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ITER = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [BW-1:0]   b_r;
    logic [BW-1:0]   b_nxt_s;
    logic [RW-1:0]   r_r;
    logic [RW-1:0]   r_nxt_s;
    logic [LW-1:0]   deg_r;
    logic [LW-1:0]   deg_nxt_s;
    logic            bsel_nxt_s;
    logic            is_last_s;
    logic            deg_le_s;
    logic [LW-1:0]   r_ext_s;
    logic            iter_nxt_s;
    logic [LW-1:0]   loc_deg_nxt_s;
`ifdef TMEC_SCHED_FAIL_EN
    logic            loc_fail_nxt_s;
`endif

    // Berlekamp length change: new L = 2r + 1 - L; never underflows because it is only used when L <= r.
    function automatic logic [LW-1:0] flip_degree(input logic [LW-1:0] r_ext, input logic [LW-1:0] deg);
        return ((r_ext << 1) | LW'(1)) - deg;
    endfunction

    assign is_last_s = (state_r == ST_ITER) && (b_r == B_LAST);
    assign r_ext_s   = LW'(r_r);
    assign deg_le_s  = (deg_r <= r_ext_s);

    // State register and bit/iteration counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            b_r     <= '0;
            r_r     <= '0;
        end else begin
            state_r <= state_nxt_s;
            b_r     <= b_nxt_s;
            r_r     <= r_nxt_s;
        end
    end

    // Next-state and counter sequencing.
    always_comb begin
        state_nxt_s = state_r;
        b_nxt_s     = b_r;
        r_nxt_s     = r_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                b_nxt_s     = '0;
                r_nxt_s     = '0;
                state_nxt_s = ST_ITER;
            end
            ST_ITER: begin
                if (b_r == B_LAST) begin
                    b_nxt_s = '0;
                    if (r_r == R_LAST) begin
                        r_nxt_s     = '0;
                        state_nxt_s = ST_DONE;
                    end else begin
                        r_nxt_s     = r_r + RW'(1);
                        state_nxt_s = ST_ITER;
                    end
                end else begin
                    b_nxt_s = b_r + BW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                b_nxt_s     = '0;
                r_nxt_s     = '0;
            end
        endcase
    end

    // Degree / length-change decision, taken once per iteration on its last cycle.
    always_comb begin
        deg_nxt_s  = deg_r;
        bsel_nxt_s = bsel;
        if (state_r == ST_LOAD) begin
            deg_nxt_s  = '0;
            bsel_nxt_s = 1'b0;
        end else if (is_last_s) begin
            if (drnzero && deg_le_s) begin
                deg_nxt_s  = flip_degree(r_ext_s, deg_r);
                bsel_nxt_s = 1'b1;
            end else begin
                deg_nxt_s  = deg_r;
                bsel_nxt_s = 1'b0;
            end
        end else begin
            deg_nxt_s  = deg_r;
            bsel_nxt_s = bsel;
        end
    end

    // Result capture: the final degree is latched on the ITER->DONE transition and held through DONE.
    // A zero discrepancy on every remaining iteration leaves L untouched, so no early exit is taken.
    always_comb begin
        loc_deg_nxt_s = loc_deg;
`ifdef TMEC_SCHED_FAIL_EN
        loc_fail_nxt_s = loc_fail;
`endif
        if ((state_r == ST_ITER) && (state_nxt_s == ST_DONE)) begin
            loc_deg_nxt_s = deg_nxt_s;
`ifdef TMEC_SCHED_FAIL_EN
            loc_fail_nxt_s = (deg_nxt_s > LW'(T));
`endif
        end else begin
            loc_deg_nxt_s = loc_deg;
        end
    end

    // Degree and select registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deg_r   <= '0;
            bsel    <= 1'b0;
            loc_deg <= '0;
`ifdef TMEC_SCHED_FAIL_EN
            loc_fail <= 1'b0;
`endif
        end else begin
            deg_r   <= deg_nxt_s;
            bsel    <= bsel_nxt_s;
            loc_deg <= loc_deg_nxt_s;
`ifdef TMEC_SCHED_FAIL_EN
            loc_fail <= loc_fail_nxt_s;
`endif
        end
    end

    assign iter_nxt_s = (state_nxt_s == ST_ITER);

    // Strobes are decoded from the next state so they come out of flops aligned with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            synpe     <= 1'b0;
            snce      <= 1'b0;
            msmpe     <= 1'b0;
            cbBeg     <= 1'b0;
            caLast    <= 1'b0;
            cce       <= 1'b0;
            dringPe   <= 1'b0;
            c0first   <= 1'b0;
            busy      <= 1'b0;
            loc_valid <= 1'b0;
        end else begin
            synpe     <= (state_nxt_s == ST_LOAD);
            snce      <= (state_nxt_s == ST_LOAD) || iter_nxt_s;
            msmpe     <= iter_nxt_s && (b_nxt_s == '0);
            cbBeg     <= iter_nxt_s && (b_nxt_s == '0);
            caLast    <= iter_nxt_s && (b_nxt_s == B_LAST);
            cce       <= iter_nxt_s;
            dringPe   <= iter_nxt_s && (b_nxt_s == '0);
            c0first   <= iter_nxt_s && (r_nxt_s == '0);
            busy      <= (state_nxt_s != ST_IDLE);
            loc_valid <= (state_nxt_s == ST_DONE);
        end
    end

endmodule

// File: tb/tb_tmec_serial_sched.sv
// Self-checking bench for tmec_serial_sched: strobe timing, degree tracking, backpressure, reset abort.
// A second T=2 instance exercises the L > T case (loc_fail when TMEC_SCHED_FAIL_EN is defined).
module tb_tmec_serial_sched;

    localparam int M  = 4;
    localparam int T  = 3;
    localparam int T2 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, drnzero, out_ready;
    logic synpe, snce, msmpe, cbBeg, caLast, cce, dringPe, c0first, bsel, busy, loc_valid;
    logic [2:0] loc_deg;
    logic start2, drnzero2, out_ready2;
    logic synpe2, snce2, msmpe2, cbBeg2, caLast2, cce2, dringPe2, c0first2, bsel2, busy2, loc_valid2;
    logic [1:0] loc_deg2;
`ifdef TMEC_SCHED_FAIL_EN
    logic loc_fail, loc_fail2;
`endif

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int exp2_q[$];

    tmec_serial_sched #(.M(M), .T(T)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .drnzero(drnzero), .out_ready(out_ready),
        .synpe(synpe), .snce(snce), .msmpe(msmpe), .cbBeg(cbBeg), .caLast(caLast), .cce(cce),
        .dringPe(dringPe), .c0first(c0first), .bsel(bsel), .busy(busy), .loc_valid(loc_valid),
`ifdef TMEC_SCHED_FAIL_EN
        .loc_fail(loc_fail),
`endif
        .loc_deg(loc_deg)
    );

    tmec_serial_sched #(.M(M), .T(T2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .drnzero(drnzero2), .out_ready(out_ready2),
        .synpe(synpe2), .snce(snce2), .msmpe(msmpe2), .cbBeg(cbBeg2), .caLast(caLast2), .cce(cce2),
        .dringPe(dringPe2), .c0first(c0first2), .bsel(bsel2), .busy(busy2), .loc_valid(loc_valid2),
`ifdef TMEC_SCHED_FAIL_EN
        .loc_fail(loc_fail2),
`endif
        .loc_deg(loc_deg2)
    );

    // Reference Berlekamp length tracking: returns final L, bsel_v[r] = length change at iteration r.
    function automatic int model_deg(input logic [7:0] pat, input int t, output logic [7:0] bsel_v);
        int l;
        l = 0;
        bsel_v = 8'd0;
        for (int r = 0; r < t; r++) begin
            if (pat[r] && (l <= r)) begin
                l = 2 * r + 1 - l;
                bsel_v[r] = 1'b1;
            end
        end
        return l;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; drnzero = 1'b0; out_ready = 1'b0;
        start2 = 1'b0; drnzero2 = 1'b0; out_ready2 = 1'b0;
        cycle();
        cycle();
        checks++;
        if ({synpe, snce, msmpe, cbBeg, caLast, cce, dringPe, c0first, bsel, busy, loc_valid, loc_deg} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%b want=0", {synpe, snce, msmpe, cbBeg, caLast, cce, dringPe, c0first, bsel, busy, loc_valid, loc_deg});
        end
        rst_n = 1'b1;
        cycle();
        checks++;
        if ({busy, loc_valid, synpe} !== 3'b000) begin
            errors++;
            $display("FAIL idle_after_reset got=%b want=000", {busy, loc_valid, synpe});
        end
    endtask

    // One full codeword on the T=3 instance; drnzero follows pat[iteration], optional downstream stall.
    task automatic run_seq(input string name, input logic [7:0] pat, input int hold, input bit timing);
        logic [7:0] bv;
        logic [9:0] got_v, exp_v;
        int d, it, c;
        bit done, in_iter;
        d = model_deg(pat, T, bv);
        exp_q.push_back(d);
        start = 1'b1; drnzero = 1'b0; out_ready = (hold == 0);
        done = 1'b0;
        c = 0;
        while (!done && c < 40) begin
            cycle();
            c++;
            start = 1'b0;
            in_iter = (c >= 2) && (c <= 1 + T * M);
            it = in_iter ? (c - 2) / M : 0;
            drnzero = in_iter ? pat[it] : 1'b0;
            if (timing) begin
                exp_v = {c == 1, (c >= 1) && (c <= 1 + T * M), in_iter && ((c - 2) % M == 0),
                         in_iter && ((c - 2) % M == 0), in_iter && ((c - 2) % M == M - 1), in_iter,
                         in_iter && ((c - 2) % M == 0), in_iter && (it == 0),
                         (c >= 1) && (c <= 2 + T * M), c == 2 + T * M};
                got_v = {synpe, snce, msmpe, cbBeg, caLast, cce, dringPe, c0first, busy, loc_valid};
                checks++;
                if (got_v !== exp_v) begin
                    errors++;
                    $display("FAIL %s strobes cycle %0d got=%b want=%b", name, c, got_v, exp_v);
                end
            end
            if (in_iter && it >= 1) begin
                checks++;
                if (bsel !== bv[it - 1]) begin
                    errors++;
                    $display("FAIL %s bsel cycle %0d got=%b want=%b", name, c, bsel, bv[it - 1]);
                end
            end
            if (loc_valid === 1'b1) begin
                done = 1'b1;
                checks++;
                if (c != 2 + T * M) begin
                    errors++;
                    $display("FAIL %s latency got=%0d want=%0d", name, c, 2 + T * M);
                end
                d = exp_q.pop_front();
                checks++;
                if (loc_deg !== 3'(d)) begin
                    errors++;
                    $display("FAIL %s loc_deg got=%0d want=%0d", name, loc_deg, d);
                end
                for (int h = 1; h < hold; h++) begin
                    start = h[0];
                    cycle();
                    checks++;
                    if ({loc_valid, busy, synpe, loc_deg} !== {3'b110, 3'(d)}) begin
                        errors++;
                        $display("FAIL %s hold cycle %0d got=%b want=%b", name, h, {loc_valid, busy, synpe, loc_deg}, {3'b110, 3'(d)});
                    end
                end
                out_ready = 1'b1;
                start = 1'b1;
                cycle();
                start = 1'b0;
                checks++;
                if ({loc_valid, busy} !== 2'b00) begin
                    errors++;
                    $display("FAIL %s after_transfer got=%b want=00", name, {loc_valid, busy});
                end
                cycle();
                checks++;
                if ({synpe, busy} !== 2'b00) begin
                    errors++;
                    $display("FAIL %s start_ignored got=%b want=00", name, {synpe, busy});
                end
            end
        end
        if (!done) begin
            errors++;
            $display("FAIL %s timeout no loc_valid within 40 cycles", name);
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_timing();
        run_seq("timing_zero", 8'b000, 0, 1'b1);
    endtask

    task automatic test_degree();
        run_seq("all_nonzero", 8'b111, 0, 1'b0);
        run_seq("mixed_101", 8'b101, 0, 1'b1);
        run_seq("back_to_back", 8'b010, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_seq("backpressure", 8'b011, 5, 1'b0);
    endtask

    task automatic test_reset_abort();
        int seen;
        start = 1'b1; out_ready = 1'b1; drnzero = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            cycle();
            start = 1'b0;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({synpe, snce, msmpe, cbBeg, caLast, cce, dringPe, c0first, bsel, busy, loc_valid, loc_deg} !== 14'd0) begin
            errors++;
            $display("FAIL async_reset got=%b want=0", {synpe, snce, msmpe, cbBeg, caLast, cce, dringPe, c0first, bsel, busy, loc_valid, loc_deg});
        end
        cycle();
        rst_n = 1'b1;
        drnzero = 1'b0;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            cycle();
            if (loc_valid === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_abort activity got=%0d want=0", seen);
        end
        run_seq("after_reset", 8'b110, 0, 1'b1);
    endtask

    // T=2 instance: pattern 0,1 gives L=3 > T, pattern 1,1 gives L=2.
    task automatic test_fail_t2();
        logic [7:0] pats [2];
        logic [7:0] bv;
        int d, c;
        bit done;
        pats[0] = 8'b10;
        pats[1] = 8'b11;
        for (int p = 0; p < 2; p++) begin
            exp2_q.push_back(model_deg(pats[p], T2, bv));
            start2 = 1'b1; out_ready2 = 1'b1; drnzero2 = 1'b0;
            done = 1'b0;
            c = 0;
            while (!done && c < 30) begin
                cycle();
                c++;
                start2 = 1'b0;
                drnzero2 = (c >= 2 && c <= 1 + T2 * M) ? pats[p][(c - 2) / M] : 1'b0;
                if (loc_valid2 === 1'b1) begin
                    done = 1'b1;
                    d = exp2_q.pop_front();
                    checks++;
                    if (loc_deg2 !== 2'(d) || c != 2 + T2 * M) begin
                        errors++;
                        $display("FAIL t2_deg pat %b got=%0d@%0d want=%0d@%0d", pats[p], loc_deg2, c, d, 2 + T2 * M);
                    end
`ifdef TMEC_SCHED_FAIL_EN
                    checks++;
                    if (loc_fail2 !== (d > T2)) begin
                        errors++;
                        $display("FAIL t2_loc_fail pat %b got=%b want=%b", pats[p], loc_fail2, d > T2);
                    end
`endif
                end
            end
            if (!done) begin
                errors++;
                $display("FAIL t2 timeout pat %b", pats[p]);
                void'(exp2_q.pop_front());
            end
            cycle();
            checks++;
            if (loc_valid2 !== 1'b0) begin
                errors++;
                $display("FAIL t2_release got=%b want=0", loc_valid2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_degree();
        test_backpressure();
        test_reset_abort();
        test_fail_t2();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
